// File: rtl/com_spi_pkg.sv
// Shared types and constants for the COM-link SPI controller.
package com_spi_pkg;

    localparam int COM_WORD_W = 16;
    localparam int BIT_CNT_W  = 5;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    // Width of a down-counter that must hold the larger of two phase lengths.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/com_spi_phase_timer.sv
// Loadable down-counter; phase_done is high on the last cycle of a loaded phase.
module com_spi_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         phase_done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A phase of N cycles sees the count N, N-1, ..., 1.
    assign phase_done = (cnt == W'(1));

endmodule

// File: rtl/com_spi_controller.sv
// SoC-side SPI mode-0 controller: one 16-bit word per chip-select frame,
// MSB first, full duplex, with a minimum csn-high gap between frames.
module com_spi_controller
    import com_spi_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        spi_sclk,
    output logic        spi_copi,
    input  logic        spi_cipo,
    output logic        spi_csn
);

    localparam int TW = timer_width(CLK_DIV, GAP_CYCLES);

    state_t                  state;
    logic [COM_WORD_W-2:0]   tx_shift;   // bits still to send; the current bit sits in spi_copi
    logic [COM_WORD_W-1:0]   rx_shift;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic                    accept;
    logic                    timer_load;
    logic                    phase_done;
    logic [TW-1:0]           load_val;

    assign accept     = (state == IDLE) && tx_valid && tx_ready;
    assign timer_load = accept || ((state != IDLE) && phase_done);
    assign load_val   = (state == HOLD) ? TW'(GAP_CYCLES) : TW'(CLK_DIV);

    com_spi_phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_val   (load_val),
        .phase_done (phase_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
            spi_csn  <= 1'b1;
            spi_sclk <= 1'b0;
            spi_copi <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_shift <= tx_data[COM_WORD_W-2:0];
                        spi_copi <= tx_data[COM_WORD_W-1];
                        spi_csn  <= 1'b0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        state    <= SETUP;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    if (phase_done) begin
                        spi_sclk <= 1'b1;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_done) begin
                        rx_shift <= {rx_shift[COM_WORD_W-2:0], spi_cipo};
                        spi_sclk <= 1'b0;
                        if (bit_cnt == BIT_CNT_W'(COM_WORD_W - 1)) begin
                            state <= HOLD;
                        end else begin
                            // Next bit goes out on the falling edge so it is stable before the next rise.
                            spi_copi <= tx_shift[COM_WORD_W-2];
                            tx_shift <= {tx_shift[COM_WORD_W-3:0], 1'b0};
                            bit_cnt  <= bit_cnt + 1'b1;
                            state    <= LOW;
                        end
                    end
                end
                LOW: begin
                    if (phase_done) begin
                        spi_sclk <= 1'b1;
                        state    <= HIGH;
                    end
                end
                HOLD: begin
                    if (phase_done) begin
                        spi_csn  <= 1'b1;
                        spi_copi <= 1'b0;
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    if (phase_done) begin
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_com_spi_controller.sv
// Directed bench: CLK_DIV=2 and CLK_DIV=1 instances, loopback or a mode-0 peripheral model.
module tb_com_spi_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        sel = 1'b0;
    logic        lb = 1'b1;
    logic [15:0] mresp = '0;
    logic [15:0] msh = '0;
    logic        mcipo = 1'b0;
    logic [15:0] model_rx = '0;

    logic        ready0, rxv0, busy0, sclk0, copi0, csn0, cipo0;
    logic        ready1, rxv1, busy1, sclk1, copi1, csn1;
    logic [15:0] rxd0, rxd1;
    logic        m_ready, m_rxv, m_busy, m_sclk, m_copi, m_csn;
    logic [15:0] m_rxd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign cipo0 = lb ? copi0 : mcipo;

    com_spi_controller #(.CLK_DIV(2), .GAP_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid && !sel),
        .tx_ready(ready0), .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0),
        .spi_sclk(sclk0), .spi_copi(copi0), .spi_cipo(cipo0), .spi_csn(csn0)
    );

    com_spi_controller #(.CLK_DIV(1), .GAP_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid && sel),
        .tx_ready(ready1), .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1),
        .spi_sclk(sclk1), .spi_copi(copi1), .spi_cipo(copi1), .spi_csn(csn1)
    );

    assign m_ready = sel ? ready1 : ready0;
    assign m_rxv   = sel ? rxv1   : rxv0;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_sclk  = sel ? sclk1  : sclk0;
    assign m_copi  = sel ? copi1  : copi0;
    assign m_csn   = sel ? csn1   : csn0;
    assign m_rxd   = sel ? rxd1   : rxd0;

    // Mode-0 peripheral: first bit valid at csn fall, shifts on each sclk fall.
    always @(negedge csn0) begin
        msh   = mresp;
        mcipo = msh[15];
    end
    always @(negedge sclk0) begin
        if (!csn0) begin
            msh   = {msh[14:0], 1'b0};
            mcipo = msh[15];
        end
    end
    always @(posedge m_sclk) model_rx = {model_rx[14:0], m_copi};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        s;
        logic        l;
        logic [15:0] tx;
        logic [15:0] resp;
        logic [15:0] exp_rx;
        int          exp_csn;
        int          exp_rxcyc;
        int          exp_ready;
    } vec_t;

    vec_t vt[4];

    // Accept one word, observe the frame at negedges (cycle 1 = first after accept).
    task automatic run_frame(input string tag, input logic s, input logic l,
                             input logic [15:0] tx, input logic [15:0] resp,
                             input logic [15:0] exp_rx, input int exp_csn,
                             input int exp_rxcyc, input int exp_ready,
                             input int p1, input int p2);
        int n, cyc, csn_lo, rises, pulses, rxcyc, readycyc, extra;
        logic prev_sclk;
        sel = s; lb = l; mresp = resp; tx_data = tx; model_rx = '0;
        n = 0;
        @(negedge clk);
        while (!m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready_before_accept"}, m_ready, 1);
        if (!m_ready) return;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        cyc = 1; csn_lo = 0; rises = 0; pulses = 0; rxcyc = -1; readycyc = -1;
        prev_sclk = 1'b0;
        while (readycyc < 0 && cyc < 400) begin
            if (!m_csn) csn_lo++;
            if (m_sclk && !prev_sclk) rises++;
            prev_sclk = m_sclk;
            if (m_rxv) begin
                pulses++;
                if (rxcyc < 0) rxcyc = cyc;
            end
            if (m_ready) readycyc = cyc;
            if (cyc == p1 || cyc == p2) begin
                tx_valid = 1'b1;
                tx_data  = 16'hDEAD;
            end else begin
                tx_valid = 1'b0;
            end
            if (readycyc < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        tx_valid = 1'b0;
        chk({tag, " rx_data"}, m_rxd, exp_rx);
        chk({tag, " rx_pulses"}, pulses, 1);
        chk({tag, " rx_cycle"}, rxcyc, exp_rxcyc);
        chk({tag, " csn_low"}, csn_lo, exp_csn);
        chk({tag, " sclk_rises"}, rises, 16);
        chk({tag, " ready_cycle"}, readycyc, exp_ready);
        chk({tag, " busy_at_ready"}, m_busy, 0);
        chk({tag, " peripheral_saw"}, model_rx, tx);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!m_csn) extra++;
        end
        chk({tag, " no_extra_frame"}, extra, 0);
    endtask

    initial begin
        int n, nrx, nf, gaphi, rises;
        int fall[2];
        logic [15:0] rxw[2];
        logic prev_csn, prev_sclk;

        vt[0] = '{1'b0, 1'b1, 16'hA503, 16'h0000, 16'hA503, 66, 67, 69};
        vt[1] = '{1'b0, 1'b0, 16'h1234, 16'h5AFC, 16'h5AFC, 66, 67, 69};
        vt[2] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 33, 34, 36};
        vt[3] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 33, 34, 36};

        // Reset values, then tx_ready rises on the first edge after release.
        @(negedge clk);
        chk("rst csn", csn0, 1);
        chk("rst sclk", sclk0, 0);
        chk("rst copi", copi0, 0);
        chk("rst rx_valid", rxv0, 0);
        chk("rst rx_data", rxd0, 0);
        chk("rst busy", busy0, 0);
        chk("rst tx_ready", ready0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel tx_ready_low", ready0, 0);
        @(negedge clk);
        chk("rel tx_ready_high", ready0, 1);

        for (int i = 0; i < 4; i++) begin
            run_frame($sformatf("vec%0d", i), vt[i].s, vt[i].l, vt[i].tx, vt[i].resp,
                      vt[i].exp_rx, vt[i].exp_csn, vt[i].exp_rxcyc, vt[i].exp_ready, -1, -1);
        end

        // Back-to-back frames with tx_valid held high; tx_data changes right after accept.
        sel = 1'b0; lb = 1'b1; tx_data = 16'h0001;
        @(negedge clk);
        tx_valid = 1'b1;
        nrx = 0; nf = 0; gaphi = 0; prev_csn = 1'b1;
        fall[0] = 0; fall[1] = 0; rxw[0] = '0; rxw[1] = '0;
        for (int c = 1; c < 400 && nrx < 2; c++) begin
            @(negedge clk);
            if (c == 1) tx_data = 16'h8000;
            if (prev_csn && !csn0 && nf < 2) begin
                fall[nf] = c;
                nf++;
            end
            prev_csn = csn0;
            if (rxv0 && nrx < 2) begin
                rxw[nrx] = rxd0;
                nrx++;
            end
            if (nf == 1 && csn0 && busy0) gaphi++;
        end
        tx_valid = 1'b0;
        chk("b2b rx_count", nrx, 2);
        chk("b2b rx0", rxw[0], 16'h0001);
        chk("b2b rx1", rxw[1], 16'h8000);
        chk("b2b period", fall[1] - fall[0], 69);
        chk("b2b gap_busy_csn_high", gaphi, 2);
        n = 0;
        while (busy0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b2b done", busy0, 0);

        // Reset after the 7th sclk rise: outputs clear at once, no rx pulse.
        sel = 1'b0; lb = 1'b1; tx_data = 16'hFFFF;
        n = 0;
        while (!ready0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        rises = 0; prev_sclk = 1'b0; n = 0;
        while (rises < 7 && n < 200) begin
            if (sclk0 && !prev_sclk) rises++;
            prev_sclk = sclk0;
            if (rises < 7) begin
                @(negedge clk);
                n++;
            end
        end
        chk("mid rises_reached", rises, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid csn", csn0, 1);
        chk("mid sclk", sclk0, 0);
        chk("mid busy", busy0, 0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rxv0) n++;
        end
        chk("mid no_rx_valid", n, 0);
        chk("mid rx_data", rxd0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid rel_ready_low", ready0, 0);
        @(negedge clk);
        chk("mid rel_ready_high", ready0, 1);
        run_frame("post_rst", 1'b0, 1'b1, 16'hC3C3, 16'h0000, 16'hC3C3, 66, 67, 69, -1, -1);

        // tx_valid pokes during HIGH (cycle 3) and the last GAP cycle (68) must be ignored.
        run_frame("ignore", 1'b0, 1'b1, 16'h0F0F, 16'h0000, 16'h0F0F, 66, 67, 69, 3, 68);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
